sonar_scheduler: RTL

Time-multiplexes up to N ultrasonic proximity_sensor instances so only one sensor is pinging at a time, which prevents acoustic crosstalk. On each start pulse (normally the 250 ms refresher pulse) it runs one sweep over the enabled sensors in ascending index order. For each sensor it issues a one-cycle measure pulse, waits for completion with a timeout, captures the distance, then enforces a guard gap before the next sensor. It sits between refresher250ms and the sensor bank in top_level.

---
 rtl/sonar_if.sv | 36 +++
 rtl/sonar_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sonar_if.sv
`default_nettype none
// ============================================================================
// Module : sonar_if
// Brief  : Control, sensor-bank and result bundle for sonar_scheduler.
// Rev    : 1.0
// ============================================================================
interface sonar_if #(
    parameter int N_SENSORS = 4,
    parameter int DIST_W    = 22
);
    logic                          en;
    logic                          start;
    logic [N_SENSORS-1:0]          sensor_mask;
    logic [N_SENSORS-1:0]          sens_ready;
    logic [N_SENSORS*DIST_W-1:0]   sens_dist;
    logic [N_SENSORS-1:0]          sens_measure;
    logic [N_SENSORS*DIST_W-1:0]   dist_out;
    logic [N_SENSORS-1:0]          dist_valid;
    logic [N_SENSORS-1:0]          timeout_flag;
    logic [2:0]                    cur_sensor;
    logic                          busy;
    logic                          sweep_done;

    modport master (
        output en, start, sensor_mask, sens_ready, sens_dist,
        input  sens_measure, dist_out, dist_valid, timeout_flag,
               cur_sensor, busy, sweep_done
    );

    modport slave (
        input  en, start, sensor_mask, sens_ready, sens_dist,
        output sens_measure, dist_out, dist_valid, timeout_flag,
               cur_sensor, busy, sweep_done
    );
endinterface
`default_nettype wire

// File: rtl/sonar_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sonar_scheduler
// Brief  : Sequences one-at-a-time pings over a bank of ultrasonic sensors.
// Rev    : 1.0
// ============================================================================
module sonar_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int DIST_W         = 22,
    parameter int GUARD_CYCLES   = 500000,
    parameter int TIMEOUT_CYCLES = 3000000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sonar_if.slave    sif
);
    localparam int c_IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_GW-1:0] c_GRD_LAST = c_GW'(GUARD_CYCLES - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ARM       = 3'd1;
    localparam logic [2:0] c_TRIG      = 3'd2;
    localparam logic [2:0] c_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_GUARD     = 3'd5;
    localparam logic [2:0] c_DONE      = 3'd6;

    logic [2:0]                  r_state, w_next;
    logic [N_SENSORS-1:0]        r_mask;
    logic [c_IW-1:0]             r_cur;
    logic [c_TW-1:0]             r_tcnt;
    logic [c_GW-1:0]             r_gcnt;
    logic [N_SENSORS-1:0]        r_valid, r_tmo;
    logic [N_SENSORS*DIST_W-1:0] r_dist;
    logic                        r_busy, r_done;

    logic [N_SENSORS-1:0]        w_sel, w_above, w_measure;
    logic                        w_rdy, w_tmo, w_more, w_accept, w_last_grd;
    logic                        w_capture, w_expire;
    logic [2:0]                  w_after;

    function automatic logic [c_IW-1:0] f_lowest(input logic [N_SENSORS-1:0] m);
        f_lowest = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = c_IW'(i);
        end
    endfunction

    assign w_sel      = N_SENSORS'(1) << r_cur;
    assign w_rdy      = |(sif.sens_ready & w_sel);
    assign w_tmo      = (r_tcnt >= c_TMO_LAST);
    // Sensors strictly above the current index that are still in this sweep
    assign w_above    = r_mask & ~((N_SENSORS'(2) << r_cur) - N_SENSORS'(1));
    assign w_more     = |w_above;
    assign w_after    = w_more ? c_GUARD : c_DONE;
    assign w_accept   = (r_state == c_IDLE) && sif.start && sif.en;
    assign w_last_grd = (r_gcnt == c_GRD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!sif.en) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:      if (sif.start) w_next = (|sif.sensor_mask) ? c_ARM : c_DONE;
                c_ARM:       if (w_rdy) w_next = c_TRIG;
                             else if (w_expire) w_next = w_after;
                c_TRIG:      w_next = c_WAIT_BUSY;
                c_WAIT_BUSY: if (!w_rdy) w_next = c_WAIT_DONE;
                             else if (w_expire) w_next = w_after;
                c_WAIT_DONE: if (w_capture || w_expire) w_next = w_after;
                c_GUARD:     if (w_last_grd) w_next = c_ARM;
                c_DONE:      w_next = c_IDLE;
                default:     w_next = c_IDLE;
            endcase
        end
    end

    // Completion is checked before the timeout so a simultaneous ready wins
    always_comb begin
        w_measure = '0;
        w_capture = 1'b0;
        w_expire  = 1'b0;
        if (sif.en) begin
            if (r_state == c_TRIG) w_measure = w_sel;
            w_capture = (r_state == c_WAIT_DONE) && w_rdy;
            w_expire  = w_tmo && (((r_state == c_ARM)       && !w_rdy) ||
                                  ((r_state == c_WAIT_BUSY) &&  w_rdy) ||
                                  ((r_state == c_WAIT_DONE) && !w_rdy));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_cur   <= '0;
            r_tcnt  <= '0;
            r_gcnt  <= '0;
            r_valid <= '0;
            r_tmo   <= '0;
            r_dist  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mask  <= sif.sensor_mask;
                r_cur   <= f_lowest(sif.sensor_mask);
                r_valid <= '0;
                r_tmo   <= '0;
            end
            if (sif.en && (r_state == c_GUARD) && w_last_grd)
                r_cur <= f_lowest(w_above);

            case (r_state)
                c_ARM, c_WAIT_BUSY, c_WAIT_DONE: r_tcnt <= r_tcnt + 1'b1;
                c_TRIG:                          r_tcnt <= r_tcnt;
                default:                         r_tcnt <= '0;
            endcase

            if (r_state == c_GUARD) r_gcnt <= r_gcnt + 1'b1;
            else                    r_gcnt <= '0;

            for (int i = 0; i < N_SENSORS; i++) begin
                if (r_cur == c_IW'(i)) begin
                    if (w_capture) begin
                        r_dist[i*DIST_W +: DIST_W] <= sif.sens_dist[i*DIST_W +: DIST_W];
                        r_valid[i]                 <= 1'b1;
                    end else if (w_expire) begin
                        r_dist[i*DIST_W +: DIST_W] <= '1;
                        r_tmo[i]                   <= 1'b1;
                    end
                end
            end

            if (!sif.en || (r_state == c_DONE)) r_busy <= 1'b0;
            else if (w_accept)                  r_busy <= 1'b1;

            r_done <= sif.en && (r_state == c_DONE);
        end
    end

    assign sif.sens_measure = w_measure;
    assign sif.dist_out     = r_dist;
    assign sif.dist_valid   = r_valid;
    assign sif.timeout_flag = r_tmo;
    assign sif.cur_sensor   = 3'(r_cur);
    assign sif.busy         = r_busy;
    assign sif.sweep_done   = r_done;

endmodule
`default_nettype wire
